disp_cro: RTL and testbench

DISP_CRO -- requirements
Module: disp_cro

---
 rtl/disp_cro_pkg.sv | 64 ++++++
 rtl/disp_cro_bin2bcd_seq.sv | 74 +++++++
 rtl/disp_cro.sv | 132 +++++++++++++
 tb/tb_disp_cro.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_cro_pkg.sv
// disp_cro_pkg: shared constants for the stopwatch display block.
// Holds the active-low gfedcba digit codes, the blank code, digit count,
// converter FSM state encoding and small helpers used by the RTL.
package disp_cro_pkg;

    localparam int unsigned NUM_DIGITS   = 5;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned SEG_W        = 7;
    localparam int unsigned BIN_W        = 10;
    localparam int unsigned BCD_W        = 16;
    localparam int unsigned SHIFT_CYCLES = 10;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // BCD digit to segment code; non-decimal values show blank
    function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] value);
        logic [BCD_W-1:0] result;
        result = value;
        for (int n = 0; n < BCD_W / DIGIT_W; n++) begin
            if (value[n*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                result[n*DIGIT_W +: DIGIT_W] = value[n*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/disp_cro_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// IDLE (1 cycle, samples bin when start) -> SHIFT (10 cycles, MSB first)
// -> DONE (1 cycle, done=1 with bcd valid) -> IDLE.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a conversion from IDLE (tie high to free-run)
//   bin[9:0]   : binary input, captured in IDLE
//   bcd[15:0]  : registered BCD result {thousands,hundreds,tens,units}
//   done       : registered, high for the single DONE cycle
module bin2bcd_seq
    import disp_cro_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned CNT_W = 4;

    conv_state_t      state;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] acc;
    logic [CNT_W-1:0] bit_cnt;
    logic [BCD_W-1:0] acc_adj_c;
    logic [BCD_W-1:0] acc_next_c;

    // One double-dabble step: correct, then shift in the next binary MSB
    assign acc_adj_c  = bcd_add3(acc);
    assign acc_next_c = {acc_adj_c[BCD_W-2:0], bin_sr[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bin_sr  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr  <= bin;
                        acc     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc     <= acc_next_c;
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    // Result and done are published together on the last shift
                    if (bit_cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
                        bcd   <= acc_next_c;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/disp_cro.sv
// disp_cro: five-digit multiplexed 7-segment stopwatch display.
// Converts seconds (binary) to BCD with bin2bcd_seq, snapshots tenths with
// the same conversion, updates all digits atomically on converter done and
// scans one digit per REFRESH_DIV clocks.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 4..2 (digits 1 and 0 are always shown).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   segundos[9:0]       : seconds, binary 0..1023
//   counter_Dezenas[3:0]: tenths, values above 9 display as 0
//   seg[6:0]            : {g,f,e,d,c,b,a}, active-low, registered
//   an[4:0]             : digit enables, active-low one-hot, registered
//   dp                  : decimal point, active-low, lit with digit 1
module disp_cro
    import disp_cro_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      segundos,
    input  logic [DIGIT_W-1:0]    counter_Dezenas,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic                                conv_idle;
    logic                                conv_done;
    logic [BCD_W-1:0]                    conv_bcd;
    logic [DIGIT_W-1:0]                  tenths_snap;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits;
    logic [CNT_W-1:0]                    refresh_cnt;
    logic [IDX_W-1:0]                    idx;
    logic [NUM_DIGITS-1:0]               lead_blank_c;
    logic [DIGIT_W-1:0]                  cur_digit_c;
    logic                                cur_blank_c;
    logic [NUM_DIGITS-1:0]               an_c;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (1'b1),
        .bin   (segundos),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // conv_idle mirrors the converter's IDLE cycle so tenths are captured
    // on the same edge that the converter captures segundos
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_idle   <= 1'b1;
            tenths_snap <= '0;
        end else begin
            conv_idle <= conv_done;
            if (conv_idle) begin
                tenths_snap <= counter_Dezenas;
            end
        end
    end

    // All five digits change together, only when a conversion completes
    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
        end else if (conv_done) begin
            digits[4] <= conv_bcd[15:12];
            digits[3] <= conv_bcd[11:8];
            digits[2] <= conv_bcd[7:4];
            digits[1] <= conv_bcd[3:0];
            digits[0] <= (tenths_snap <= 4'd9) ? tenths_snap : 4'd0;
        end
    end

    // Refresh divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked only if it and every more-significant digit are zero
    always_comb begin
        lead_blank_c    = '0;
        lead_blank_c[4] = (digits[4] == 4'd0);
        lead_blank_c[3] = lead_blank_c[4] && (digits[3] == 4'd0);
        lead_blank_c[2] = lead_blank_c[3] && (digits[2] == 4'd0);
    end
`else
    assign lead_blank_c = '0;
`endif

    // Digit select for the current scan position
    always_comb begin
        cur_digit_c = digits[0];
        cur_blank_c = 1'b0;
        case (idx)
            3'd0: begin cur_digit_c = digits[0]; cur_blank_c = lead_blank_c[0]; end
            3'd1: begin cur_digit_c = digits[1]; cur_blank_c = lead_blank_c[1]; end
            3'd2: begin cur_digit_c = digits[2]; cur_blank_c = lead_blank_c[2]; end
            3'd3: begin cur_digit_c = digits[3]; cur_blank_c = lead_blank_c[3]; end
            3'd4: begin cur_digit_c = digits[4]; cur_blank_c = lead_blank_c[4]; end
            default: begin cur_digit_c = '0; cur_blank_c = 1'b1; end
        endcase
        an_c = ~(NUM_DIGITS'(1) << idx);
    end

    // seg, an and dp are all registered from the same idx value
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= cur_blank_c ? SEG_BLANK : seg_encode(cur_digit_c);
            an  <= an_c;
            dp  <= (idx != IDX_W'(1));
        end
    end

endmodule

// File: tb/tb_disp_cro.sv
// tb_disp_cro: self-checking bench for disp_cro with REFRESH_DIV=4.
// Expected scan outputs are pushed to a scoreboard queue when stimulus is
// applied and popped/compared as the DUT produces them.
module tb_disp_cro;

    localparam int unsigned RDIV = 4;

    typedef struct packed {
        logic [4:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] segundos;
    logic [3:0] counter_Dezenas;
    logic [6:0] seg;
    logic [4:0] an;
    logic       dp;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    disp_cro #(.REFRESH_DIV(RDIV)) dut (
        .clk             (clk),
        .rst             (rst),
        .segundos        (segundos),
        .counter_Dezenas (counter_Dezenas),
        .seg             (seg),
        .an              (an),
        .dp              (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // {thousands, hundreds, tens, units, tenths}
    function automatic logic [19:0] frame_of(input int sec, input int ten);
        logic [19:0] f;
        f[19:16] = 4'(sec / 1000);
        f[15:12] = 4'((sec / 100) % 10);
        f[11:8]  = 4'((sec / 10) % 10);
        f[7:4]   = 4'(sec % 10);
        f[3:0]   = (ten <= 9) ? 4'(ten) : 4'd0;
        return f;
    endfunction

    function automatic obs_t exp_out(input logic [19:0] fr, input int idx);
        obs_t r;
        logic [3:0] d;
        logic blank;
        d     = fr[idx*4 +: 4];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 4) blank = (fr[19:16] == 4'd0);
        if (idx == 3) blank = (fr[19:12] == 8'd0);
        if (idx == 2) blank = (fr[19:8] == 12'd0);
`endif
        r.an      = 5'b11111;
        r.an[idx] = 1'b0;
        r.seg     = blank ? 7'b1111111 : seg_of(d);
        r.dp      = (idx == 1) ? 1'b0 : 1'b1;
        return r;
    endfunction

    // Cycle k = k-th posedge after reset release; scan index derives from k
    task automatic push_cycles(input int k0, input int k1, input logic [19:0] fr);
        for (int k = k0; k <= k1; k++) begin
            exp_q.push_back(exp_out(fr, ((k - 1) / int'(RDIV)) % 5));
        end
    endtask

    task automatic pop_compare(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_underflow"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_an", tag),  32'(an),  32'(e.an));
            chk($sformatf("%s_seg", tag), 32'(seg), 32'(e.seg));
            chk($sformatf("%s_dp", tag),  32'(dp),  32'(e.dp));
        end
    endtask

    task automatic run_checks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pop_compare($sformatf("%s_c%0d", tag, i));
        end
    endtask

    task automatic wait_an(input logic [4:0] target, input string tag);
        int n;
        n = 0;
        while (an !== target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(an), 32'(target));
    endtask

    // Apply inputs, allow the worst-case latency, then check one full scan
    task automatic scan_test(input int sec, input int ten, input string tag);
        logic [19:0] fr;
        segundos        = 10'(sec);
        counter_Dezenas = 4'(ten);
        repeat (24) @(negedge clk);
        fr = frame_of(sec, ten);
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_out(fr, i));
        wait_an(5'b11110, {tag, "_sync"});
        for (int i = 0; i < 5; i++) begin
            pop_compare($sformatf("%s_d%0d", tag, i));
            repeat (RDIV) @(negedge clk);
        end
    endtask

    initial begin
        rst             = 1'b1;
        segundos        = 10'd1023;
        counter_Dezenas = 4'd7;

        // Held reset: outputs dark every cycle
        repeat (5) begin
            @(negedge clk);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_an",  32'(an),  32'h1F);
            chk("rst_dp",  32'(dp),  32'h1);
        end

        // Release: zeros until the first conversion lands, then 1023.7
        rst = 1'b0;
        push_cycles(1, 12, 20'h0);
        push_cycles(13, 40, frame_of(1023, 7));
        run_checks(40, "boot");

        // One-cycle reset while digit 3 is shown aborts scan and display
        wait_an(5'b10111, "sync_idx3");
        rst = 1'b1;
        @(negedge clk);
        chk("pulse_seg", 32'(seg), 32'h7F);
        chk("pulse_an",  32'(an),  32'h1F);
        chk("pulse_dp",  32'(dp),  32'h1);
        rst = 1'b0;
        push_cycles(1, 12, 20'h0);
        push_cycles(13, 24, frame_of(1023, 7));
        run_checks(24, "pulse");

        // Steady-state patterns, including tenths out of range
        scan_test(5, 0, "s5");
        scan_test(3, 10, "s3t10");
        scan_test(999, 9, "s999");
        scan_test(1000, 15, "s1000t15");
        scan_test(0, 0, "s0");

        // Input change during the 5th SHIFT of the second conversion
        rst             = 1'b1;
        segundos        = 10'd100;
        counter_Dezenas = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        push_cycles(1, 12, 20'h0);
        push_cycles(13, 36, frame_of(100, 0));
        push_cycles(37, 56, frame_of(200, 0));
        run_checks(17, "mid_a");
        segundos = 10'd200;
        run_checks(39, "mid_b");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
